// File: rtl/squash_unit_l1.sv
// Level-1 squash arbiter: forwards the squash of the oldest in-flight instruction,
// judging age by wrap-around sequence number relative to the commit stream.
module squash_unit_l1 #(
   parameter int p_num_arb      = 2,
   parameter int p_seq_num_bits = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_num_arb-1:0]                  arb_val,
   input  logic [p_num_arb*p_seq_num_bits-1:0]   arb_seq_num,
   input  logic [p_num_arb*32-1:0]               arb_target,
   output logic                                  gnt_val,
   output logic [p_seq_num_bits-1:0]             gnt_seq_num,
   output logic [31:0]                           gnt_target,
   input  logic                                  commit_val,
   input  logic [p_seq_num_bits-1:0]             commit_seq_num,
   input  logic [31:0]                           commit_pc,
   input  logic [4:0]                            commit_waddr,
   input  logic [31:0]                           commit_wdata,
   input  logic                                  commit_wen
);

   localparam int W = p_seq_num_bits;

   // Oldest possibly in-flight sequence number; ages are measured from here.
   logic [W-1:0] seq_ref;

   // Commit-side fields other than the sequence number carry no age information.
   logic unused_commit;
   assign unused_commit = ^{commit_pc, commit_waddr, commit_wdata, commit_wen};

   // NOTE: non-blocking assignment so every reader sees the pre-edge value of seq_ref.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq_ref <= '0;
      end else if (commit_val) begin
         seq_ref <= commit_seq_num + 1'b1;
      end
   end

   logic          best_found;
   logic [W-1:0]  best_age;
   logic [W-1:0]  best_seq;
   logic [31:0]   best_tgt;
   logic [W-1:0]  cand_seq;
   logic [W-1:0]  cand_age;

   // Linear scan; strict less-than keeps the lowest index on equal ages.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      best_found = 1'b0;
      best_age   = '0;
      best_seq   = '0;
      best_tgt   = '0;
      cand_seq   = '0;
      cand_age   = '0;
      for (int i = 0; i < p_num_arb; i++) begin
         cand_seq = arb_seq_num[i*W +: W];
         cand_age = cand_seq - seq_ref;
         if (arb_val[i] && (!best_found || (cand_age < best_age))) begin
            best_found = 1'b1;
            best_age   = cand_age;
            best_seq   = cand_seq;
            best_tgt   = arb_target[i*32 +: 32];
         end
      end
   end

   assign gnt_val     = |arb_val;
   assign gnt_seq_num = best_seq;
   assign gnt_target  = best_tgt;

   // Fixed-width grant string "ss:tttttttt"; blanks when idle, reference appended at level>1.
   function automatic string trace(input int level);
      string s;
      if (level <= 0) return "";
      if (gnt_val) s = $sformatf("%2d:%08h", gnt_seq_num, gnt_target);
      else         s = $sformatf("%11s", "");
      if (level > 1) s = {s, $sformatf(" r=%2d", seq_ref)};
      return s;
   endfunction

endmodule

// File: tb/tb_squash_unit_l1.sv
// Directed bench for squash_unit_l1: single requesters, wrap-around age, ties,
// same-edge commit ordering, asynchronous reset and a randomized sweep.
module tb_squash_unit_l1;

   localparam int N  = 4;
   localparam int W  = 5;
   localparam int TW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    arb_val = '0;
   logic [N*W-1:0]  arb_seq_num = '0;
   logic [N*32-1:0] arb_target = '0;
   logic            gnt_val;
   logic [W-1:0]    gnt_seq_num;
   logic [31:0]     gnt_target;
   logic            commit_val = 1'b0;
   logic [W-1:0]    commit_seq_num = '0;

   logic [N-1:0]    t_val = '0;
   logic [N*TW-1:0] t_seq = '0;
   logic [N*32-1:0] t_tgt = '0;
   logic            t_gnt_val;
   logic [TW-1:0]   t_gnt_seq;
   logic [31:0]     t_gnt_tgt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   squash_unit_l1 #(.p_num_arb(N), .p_seq_num_bits(W)) dut (
      .clk(clk), .rst(rst),
      .arb_val(arb_val), .arb_seq_num(arb_seq_num), .arb_target(arb_target),
      .gnt_val(gnt_val), .gnt_seq_num(gnt_seq_num), .gnt_target(gnt_target),
      .commit_val(commit_val), .commit_seq_num(commit_seq_num),
      .commit_pc(32'h0), .commit_waddr(5'h0), .commit_wdata(32'h0), .commit_wen(1'b0)
   );

   squash_unit_l1 #(.p_num_arb(N), .p_seq_num_bits(TW)) dut_t (
      .clk(clk), .rst(rst),
      .arb_val(t_val), .arb_seq_num(t_seq), .arb_target(t_tgt),
      .gnt_val(t_gnt_val), .gnt_seq_num(t_gnt_seq), .gnt_target(t_gnt_tgt),
      .commit_val(1'b0), .commit_seq_num(3'h0),
      .commit_pc(32'h0), .commit_waddr(5'h0), .commit_wdata(32'h0), .commit_wen(1'b0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_gnt(input string tag, input logic v, input logic [W-1:0] s,
                            input logic [31:0] t);
      check({tag, ".val"}, 64'(gnt_val), 64'(v));
      check({tag, ".seq"}, 64'(gnt_seq_num), 64'(s));
      check({tag, ".tgt"}, 64'(gnt_target), 64'(t));
   endtask

   task automatic set_arb(input int i, input logic [W-1:0] s, input logic [31:0] t);
      arb_val[i]            = 1'b1;
      arb_seq_num[i*W +: W] = s;
      arb_target[i*32 +: 32] = t;
   endtask

   task automatic clear_arb();
      arb_val     = '0;
      arb_seq_num = '0;
      arb_target  = '0;
   endtask

   // Commits seq s on the next rising edge, then returns mid-cycle.
   task automatic do_commit(input logic [W-1:0] s);
      commit_val     = 1'b1;
      commit_seq_num = s;
      @(posedge clk);
      #2;
      commit_val     = 1'b0;
   endtask

   logic [W-1:0]  m_ref;
   logic [W-1:0]  r_seq [N];
   logic [31:0]   r_tgt [N];
   logic          e_val;
   logic [W-1:0]  e_seq;
   logic [31:0]   e_tgt;
   logic          dup;

   initial begin
      // Reset state: no requests, outputs idle.
      #3;
      check_gnt("reset_idle", 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;

      // Each requester alone, reference 0.
      for (int i = 0; i < N; i++) begin
         clear_arb();
         set_arb(i, W'(7 + i), 32'h1000 + 32'(i * 'h100));
         #1;
         check_gnt($sformatf("single%0d", i), 1'b1, W'(7 + i), 32'h1000 + 32'(i * 'h100));
      end
      clear_arb();
      #1;
      check_gnt("none_valid", 1'b0, '0, '0);

      // Wrap-around: reference 30, seq 31 is older than seq 2.
      do_commit(5'd29);
      set_arb(0, 5'd31, 32'h0000_A000);
      set_arb(1, 5'd2,  32'h0000_B000);
      #1;
      check_gnt("wrap_a", 1'b1, 5'd31, 32'h0000_A000);
      clear_arb();
      set_arb(0, 5'd2,  32'h0000_B000);
      set_arb(1, 5'd31, 32'h0000_A000);
      #1;
      check_gnt("wrap_b", 1'b1, 5'd31, 32'h0000_A000);

      // Asynchronous reset clears the reference without a clock edge.
      rst = 1'b0;
      #1;
      check_gnt("rst_async", 1'b1, 5'd2, 32'h0000_B000);
      rst = 1'b1;
      clear_arb();

      // Same-edge commit: this cycle still sees reference 0.
      @(posedge clk);
      #2;
      commit_val     = 1'b1;
      commit_seq_num = 5'd3;
      set_arb(0, 5'd3, 32'h0000_3000);
      set_arb(1, 5'd4, 32'h0000_4000);
      #1;
      check_gnt("same_edge_n", 1'b1, 5'd3, 32'h0000_3000);
      @(posedge clk);
      #2;
      commit_val = 1'b0;
      #1;
      check_gnt("same_edge_n1", 1'b1, 5'd4, 32'h0000_4000);
      clear_arb();

      // Tie on the W=3 instance: lower index wins.
      t_val = 4'b1100;
      t_seq[2*TW +: TW] = 3'd5;
      t_seq[3*TW +: TW] = 3'd5;
      t_tgt[2*32 +: 32] = 32'h0000_C000;
      t_tgt[3*32 +: 32] = 32'h0000_D000;
      #1;
      check("tie.val", 64'(t_gnt_val), 64'd1);
      check("tie.seq", 64'(t_gnt_seq), 64'd5);
      check("tie.tgt", 64'(t_gnt_tgt), 64'h0000_C000);
      t_val = 4'b0000;

      // Randomized sweep against an ascending-age scan model.
      m_ref = 5'd4;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            logic [W-1:0] cs;
            cs = W'($urandom_range(0, 31));
            do_commit(cs);
            m_ref = cs + 1'b1;
         end else begin
            @(posedge clk);
            #2;
         end
         clear_arb();
         do begin
            dup = 1'b0;
            for (int i = 0; i < N; i++) r_seq[i] = W'($urandom_range(0, 31));
            for (int i = 0; i < N; i++)
               for (int j = i + 1; j < N; j++)
                  if (r_seq[i] == r_seq[j]) dup = 1'b1;
         end while (dup);
         for (int i = 0; i < N; i++) begin
            r_tgt[i] = $urandom;
            if ($urandom_range(0, 2) != 0) set_arb(i, r_seq[i], r_tgt[i]);
         end
         e_val = 1'b0;
         e_seq = '0;
         e_tgt = '0;
         for (int d = 0; d < 32 && !e_val; d++)
            for (int i = 0; i < N; i++)
               if (!e_val && arb_val[i] && r_seq[i] == W'(m_ref + W'(d))) begin
                  e_val = 1'b1;
                  e_seq = r_seq[i];
                  e_tgt = r_tgt[i];
               end
         #1;
         check_gnt($sformatf("rand%0d", it), e_val, e_seq, e_tgt);
      end
      clear_arb();

      // Mid-run reset: reference 11 favours seq 12, reference 0 favours seq 5.
      @(posedge clk);
      #2;
      do_commit(5'd10);
      set_arb(0, 5'd5,  32'h0000_5555);
      set_arb(1, 5'd12, 32'h0000_CCCC);
      #1;
      check_gnt("pre_rst", 1'b1, 5'd12, 32'h0000_CCCC);
      rst = 1'b0;
      #1;
      check_gnt("mid_rst", 1'b1, 5'd5, 32'h0000_5555);
      rst = 1'b1;
      clear_arb();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
